dice_result_capture: RTL
========================

// Module: dice_result_capture
// PURPOSE
//  Downstream consumer of the electronic dice. Watches the same button level fed to the dice
//  and the dice throw[2:0] output. Once the button has been released and the count has settled,
//  it captures the final face and presents it on a valid/ready handshake. It also keeps per-face
//  tallies, a total roll count, a repeat (double) flag and fault flags for a display/stats stage.
// PARAMETERS
//  CNT_W   8  width of each per-face tally and of total; counters saturate at all-ones
//  SETTLE  2  cycles button must stay low before capture (legal range >=1)
// PORTS
//  clk           in   1      system clock, rising edge; single clock domain
//  rst           in   1      asynchronous, active-low reset (rst=0 resets)
//  button        in   1      roll button level, same signal driving the dice; 1 = rolling
//  throw         in   3      dice face from the dice block; legal 1..6
//  result        out  3      captured face; held stable while result_valid=1
//  result_valid  out  1      captured result available
//  result_ready  in   1      consumer accepts; transfer on edge with valid&ready
//  tally_sel     in   3      face to read (1..6)
//  tally         out  CNT_W  captures of face tally_sel; 0 when tally_sel is 0 or 7 (combinational)
//  total         out  CNT_W  total legal captures
//  double_flag   out  1      current result equals previous legal result
//  err_face      out  1      current result was 0 or 7 (dice fault)
//  overrun       out  1      sticky: press seen while a result was still unaccepted
// BEHAVIOUR
//  Reset (rst=0, async, takes effect immediately):
//   state=IDLE; result=0; result_valid=0; all tallies and total=0; double_flag=0; err_face=0;
//   overrun=0; settle_cnt=0; prev-result-exists=0. Deasserting mid-roll or mid-present restarts at IDLE.
//  FSM (all transitions on rising clk):
//   IDLE:    button=1 -> ROLLING.
//   ROLLING: button=0 -> SETTLE, settle_cnt=1.
//   SETTLE:  button=1 -> ROLLING (no capture).
//            button=0 & settle_cnt<SETTLE -> settle_cnt+1.
//            button=0 & settle_cnt==SETTLE -> capture throw, -> PRESENT.
//   PRESENT: result_valid=1. valid&ready -> IDLE; result_valid=0 from that edge.
//            button=1 & !result_ready -> overrun=1 (sticky), stay PRESENT; that roll is lost.
//            button=1 & result_ready -> IDLE; press is picked up from IDLE next cycle.
//  Latency: button sampled 0 at edge E0 (ROLLING->SETTLE); capture and result_valid=1 at edge
//   E0+SETTLE, provided button stays 0 throughout.
//  Capture edge:
//   result <= throw.
//   throw in 1..6: err_face<=0; tally[throw] and total each +1, saturating (no wrap);
//    double_flag <= prev-exists & (throw==prev); prev<=throw; prev-exists<=1.
//   throw 0 or 7: err_face<=1; double_flag<=0; tallies, total and prev unchanged.
//  result, err_face and double_flag hold until the next capture or reset; result_valid gates use.
//  result_ready is ignored outside PRESENT.
//  Only six tally registers exist (faces 1..6).
// TESTING
//  1 rst=0 -> all outputs 0, IDLE; button=1 for 5 clk, then 0; throw=4 stable ->
//    result_valid=1, result=4 exactly 2 edges after button sampled low; tally(sel=4)=1, total=1.
//  2 Hold result_ready=0 for 10 clk with button pulsed high -> result stays 4, valid stays 1,
//    overrun=1, total unchanged; then ready=1 -> valid=0 on next edge.
//  3 Release button, re-press after 1 clk (SETTLE=2) -> no capture, valid=0;
//    final release with throw=2 -> result=2, tally(sel=2)=1.
//  4 Two rolls capturing 6 then 6 -> double_flag=0 then 1; third roll captures 3 -> double_flag=0.
//  5 Force throw=3'd0 at the capture edge -> err_face=1, result=0, all tallies and total unchanged;
//    next legal roll -> err_face=0.
//  6 CNT_W=3: 9 rolls of face 1 -> tally(sel=1)=7, total=7 (saturated);
//    assert rst=0 mid-SETTLE -> everything 0, no capture.

Source files
------------

// File: rtl/dice_result_capture.sv
`default_nettype none
// ============================================================================
//  Module   : dice_result_capture
//  Captures the settled dice face after button release, presents it on a
//  valid/ready handshake and keeps per-face tallies and fault flags.
//  Revision : 1.0 - initial release
// ============================================================================
module dice_result_capture #(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [2:0]       throw,
    output logic [2:0]       result,
    output logic             result_valid,
    input  logic             result_ready,
    input  logic [2:0]       tally_sel,
    output logic [CNT_W-1:0] tally,
    output logic [CNT_W-1:0] total,
    output logic             double_flag,
    output logic             err_face,
    output logic             overrun
);

    localparam int                c_SCNT_W   = $clog2(SETTLE + 1);
    localparam logic [c_SCNT_W-1:0] c_SETTLE_V = c_SCNT_W'(SETTLE);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROLLING = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_SCNT_W-1:0] r_settle_cnt;
    logic [c_SCNT_W-1:0] w_settle_next;
    logic                w_capture;
    logic                w_overrun_set;
    logic                w_legal;
    logic [CNT_W-1:0]    r_tally [1:6];
    logic [CNT_W-1:0]    r_total;
    logic [2:0]          r_result;
    logic [2:0]          r_prev;
    logic                r_prev_ok;
    logic                r_double;
    logic                r_err;
    logic                r_overrun;

    assign w_legal = (throw != 3'd0) && (throw != 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle_cnt;
        w_capture     = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (button) w_state_next = ST_ROLLING;
            end
            ST_ROLLING: begin
                if (!button) begin
                    w_state_next  = ST_SETTLE;
                    w_settle_next = c_SCNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (button) begin
                    w_state_next = ST_ROLLING;
                end else if (r_settle_cnt == c_SETTLE_V) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_PRESENT;
                end else begin
                    w_settle_next = r_settle_cnt + 1'b1;
                end
            end
            ST_PRESENT: begin
                // A press while the consumer is stalling is dropped, not queued.
                if (result_ready) w_state_next = ST_IDLE;
                else if (button)  w_overrun_set = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result  <= '0;
            r_prev    <= '0;
            r_prev_ok <= 1'b0;
            r_double  <= 1'b0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
            r_total   <= '0;
            for (int f = 1; f <= 6; f++) r_tally[f] <= '0;
        end else begin
            if (w_overrun_set) r_overrun <= 1'b1;
            if (w_capture) begin
                r_result <= throw;
                if (w_legal) begin
                    r_err     <= 1'b0;
                    r_double  <= r_prev_ok && (throw == r_prev);
                    r_prev    <= throw;
                    r_prev_ok <= 1'b1;
                    if (r_total != c_CNT_MAX) r_total <= r_total + 1'b1;
                    for (int f = 1; f <= 6; f++) begin
                        if ((throw == 3'(f)) && (r_tally[f] != c_CNT_MAX))
                            r_tally[f] <= r_tally[f] + 1'b1;
                    end
                end else begin
                    r_err    <= 1'b1;
                    r_double <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        tally = '0;
        case (tally_sel)
            3'd1:    tally = r_tally[1];
            3'd2:    tally = r_tally[2];
            3'd3:    tally = r_tally[3];
            3'd4:    tally = r_tally[4];
            3'd5:    tally = r_tally[5];
            3'd6:    tally = r_tally[6];
            default: tally = '0;
        endcase
    end

    assign result       = r_result;
    assign result_valid = (r_state == ST_PRESENT);
    assign total        = r_total;
    assign double_flag  = r_double;
    assign err_face     = r_err;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire
